bcd_conv_sched: RTL and testbench

Sequential double-dabble conversion engine that shares a single shift/add-3 datapath between two requesters (A, B) under round-robin arbitration. It converts a 12-bit binary count to four BCD digits over 12 iterations. The engine sits between the counter blocks and the 7-segment display logic, replacing one combinational converter per requester.

---
 rtl/bcd_conv_sched.sv | 147 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
//
// Shared sequential double-dabble converter. Two requesters (A, B) compete
// for a single shift/add-3 datapath under round-robin arbitration. Each
// accepted 12-bit binary count becomes four BCD digits after 12 iterations.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_a/b    requester has a value to convert (held until acked)
//   count_a/b  binary value of each requester
//   ack_a/b    combinational grant, only while idle; transfer on req && ack
//   busy       conversion in progress (SHIFT or DONE)
//   out_valid  one-cycle pulse, digits and out_src valid
//   out_src    source of the result (0 = A, 1 = B)
//   thousands/hundreds/tens/ones  BCD result digits, held until next result
//
// Optional feature (macro BCD_CONV_SCHED_BLANK_EN): leading-zero digits are
// replaced with 4'hF (blank code); ones is never blanked. Timing is the same
// in both builds.
// ---------------------------------------------------------------------------
module bcd_conv_sched #(
  parameter int WIDTH = 12,
  parameter int ITER  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] count_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] count_b,
  output logic             ack_b,
  output logic             busy,
  output logic             out_valid,
  output logic             out_src,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [15:0]      scratch;
  logic [3:0]       iter;
  logic             src_r;
  logic             last_src;

  logic             grant_a;
  logic             grant_b;
  logic [15:0]      scratch_nxt;
  logic [15:0]      digits_nxt;

  // Per-digit add-3 correction; 4-bit add, no carry into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [15:0] adjust(input logic [15:0] s);
    return {add3(s[15:12]), add3(s[11:8]), add3(s[7:4]), add3(s[3:0])};
  endfunction

  // Leading-zero blanking from thousands downward; ones always shown.
  function automatic logic [15:0] finish_digits(input logic [15:0] s);
    logic [15:0] r;
    r = s;
`ifdef BCD_CONV_SCHED_BLANK_EN
    if (r[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    grant_a = req_a && (!req_b || last_src);
    grant_b = req_b && (!req_a || !last_src);
  end

  assign ack_a = (state == IDLE) && grant_a;
  assign ack_b = (state == IDLE) && grant_b;
  assign busy  = (state != IDLE);

  // Adjust first, then shift {scratch, bin} left; bin MSB enters scratch bit 0.
  assign scratch_nxt = {adjust(scratch)[14:0], bin[WIDTH-1]};
  assign digits_nxt  = finish_digits(scratch_nxt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      iter      <= '0;
      src_r     <= 1'b0;
      last_src  <= 1'b1;
      out_valid <= 1'b0;
      out_src   <= 1'b0;
      thousands <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ack_a || ack_b) begin
            bin      <= ack_a ? count_a : count_b;
            scratch  <= '0;
            iter     <= '0;
            src_r    <= ack_b;
            last_src <= ack_b;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          bin     <= {bin[WIDTH-2:0], 1'b0};
          iter    <= iter + 4'd1;
          // Final iteration: load the result registers on the way into DONE
          // so the digits and out_valid are both visible during DONE.
          if (iter == 4'(ITER - 1)) begin
            {thousands, hundreds, tens, ones} <= digits_nxt;
            out_src   <= src_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [11:0] count_a, count_b;
  logic        ack_a, ack_b, busy, out_valid, out_src;
  logic [3:0]  thousands, hundreds, tens, ones;

`ifdef BCD_CONV_SCHED_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd_conv_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .count_a(count_a), .ack_a(ack_a),
    .req_b(req_b), .count_b(count_b), .ack_b(ack_b),
    .busy(busy), .out_valid(out_valid), .out_src(out_src),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal reference from plain integer arithmetic.
  function automatic logic [15:0] ref_digits(input int v);
    int th, hu, te, on;
    th = v / 1000;
    hu = (v / 100) % 10;
    te = (v / 10) % 10;
    on = v % 10;
    if (BLANK && th == 0) begin
      th = 15;
      if (hu == 0) begin
        hu = 15;
        if (te == 0) te = 15;
      end
    end
    return {th[3:0], hu[3:0], te[3:0], on[3:0]};
  endfunction

  // Behavioural model: a conversion is a 13-cycle busy window after an
  // accepting edge, with the result appearing in the last cycle of it.
  int          mt    = 0;
  logic        mlast = 1'b1;
  int          mval  = 0;
  logic        msrc  = 1'b0;
  logic [15:0] mdig  = '0;
  logic        mosrc = 1'b0;

  always @(negedge clk) begin
    logic ga, gb;
    logic [15:0] d;
    ga = req_a && (!req_b || mlast);
    gb = req_b && (!req_a || !mlast);
    d  = {thousands, hundreds, tens, ones};
    chk("busy", busy, mt != 0);
    chk("out_valid", out_valid, mt == 13);
    chk("ack_a", ack_a, (mt == 0) && ga);
    chk("ack_b", ack_b, (mt == 0) && gb);
    chk("digits", d, mdig);
    chk("out_src", out_src, mosrc);
    if (out_valid && !BLANK)
      chk("digit_range", (thousands > 9) || (hundreds > 9) || (tens > 9) || (ones > 9), 0);
    if (!rst_n) begin
      mt = 0; mlast = 1'b1; mdig = '0; mosrc = 1'b0;
    end else if (mt == 0) begin
      if (ga || gb) begin
        mt = 1; mval = ga ? int'(count_a) : int'(count_b); msrc = gb; mlast = gb;
      end
    end else if (mt == 13) begin
      mt = 0;
    end else begin
      mt++;
      if (mt == 13) begin
        mdig = ref_digits(mval); mosrc = msrc;
      end
    end
  end

  task automatic wait_ack(input bit b, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (b ? ack_b : ack_a) begin got = 1; break; end
    end
    chk("ack_timeout", got, 1);
  endtask

  task automatic wait_valid(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin got = 1; break; end
    end
    chk("valid_timeout", got, 1);
  endtask

  task automatic chk_result(input string nm, input logic [15:0] exp, input logic src);
    chk({nm, "_digits"}, {thousands, hundreds, tens, ones}, exp);
    chk({nm, "_src"}, out_src, src);
  endtask

  initial begin
    int n, lat, t1, t2, t3;
    bit bad;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; count_a = '0; count_b = '0;

    // Pin the reference model with hand-computed values.
    chk("ref_4095", ref_digits(4095), 16'h4095);
    chk("ref_0", ref_digits(0), BLANK ? 16'hFFF0 : 16'h0000);
    chk("ref_987", ref_digits(987), BLANK ? 16'hF987 : 16'h0987);
    chk("ref_100", ref_digits(100), BLANK ? 16'hF100 : 16'h0100);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {thousands, hundreds, tens, ones}, 16'h0000);
    chk("rst_valid_busy", {out_valid, busy, out_src}, 0);

    // A converts 4095; ack in the first idle cycle, busy for 13 cycles.
    rst_n = 1'b1; req_a = 1'b1; count_a = 12'd4095;
    wait_ack(0, n);
    chk("first_ack_cycle", n, 1);
    @(posedge clk); #1 req_a = 1'b0;
    n = 0; bad = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (out_valid) begin bad = 0; break; end
    end
    chk("t1_seen", bad, 0);
    chk("t1_busy_cycles", n, 13);
    chk_result("t1", 16'h4095, 1'b0);

    // B converts 0.
    @(posedge clk); #1 req_b = 1'b1; count_b = 12'd0;
    wait_ack(1, n);
    @(posedge clk); #1 req_b = 1'b0;
    wait_valid(lat);
    chk("t2_latency", lat, 13);
    chk_result("t2", BLANK ? 16'hFFF0 : 16'h0000, 1'b1);

    // Both held: A, B, A with 14-cycle spacing.
    @(posedge clk); #1 req_a = 1'b1; count_a = 12'd1234; req_b = 1'b1; count_b = 12'd987;
    wait_valid(lat); t1 = cyc;
    chk_result("rr1", BLANK ? 16'h1234 : 16'h1234, 1'b0);
    wait_valid(lat); t2 = cyc;
    chk_result("rr2", BLANK ? 16'hF987 : 16'h0987, 1'b1);
    wait_valid(lat); t3 = cyc;
    chk_result("rr3", 16'h1234, 1'b0);
    chk("rr_space1", t2 - t1, 14);
    chk("rr_space2", t3 - t2, 14);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;

    // A requests while B is busy; count sampled only at its ack.
    @(posedge clk); #1 req_b = 1'b1; count_b = 12'd500;
    wait_ack(1, n);
    @(posedge clk); #1 req_b = 1'b0; req_a = 1'b1; count_a = 12'd111;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack_a) bad = 1;
    end
    chk("busy_no_ack", bad, 0);
    @(posedge clk); #1 count_a = 12'd321;
    wait_valid(lat);
    chk_result("t4b", BLANK ? 16'hF500 : 16'h0500, 1'b1);
    wait_ack(0, n);
    chk("t4_ack_in_idle", n, 1);
    @(posedge clk); #1 req_a = 1'b0;
    wait_valid(lat);
    chk_result("t4a", BLANK ? 16'hF321 : 16'h0321, 1'b0);

    // Reset during SHIFT aborts the conversion.
    @(posedge clk); #1 req_a = 1'b1; count_a = 12'd4095;
    wait_ack(0, n);
    @(posedge clk); #1 req_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy || out_src || ({thousands, hundreds, tens, ones} != 16'h0)) bad = 1;
    end
    chk("abort_quiet", bad, 0);
    @(posedge clk); #1 req_a = 1'b1; count_a = 12'd100;
    wait_ack(0, n);
    @(posedge clk); #1 req_a = 1'b0;
    wait_valid(lat);
    chk("t5_latency", lat, 13);
    chk_result("t5", BLANK ? 16'hF100 : 16'h0100, 1'b0);

    // Full sweep through A, back to back; the model checks every result.
    @(posedge clk); #1 req_a = 1'b1; count_a = 12'd0;
    for (int v = 0; v < 4096; v++) begin
      wait_ack(0, n);
      @(posedge clk);
      #1;
      if (v == 4095) req_a = 1'b0;
      else count_a = 12'(v + 1);
    end
    wait_valid(lat);
    chk_result("sweep_last", 16'h4095, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
